// File: rtl/user_func_sel.sv
// JTAG USER1 function-code stage: shifts in a code, latches it on Update-DR and
// decodes it into register selects, daisy-chain mode or a fixed-length command strobe.
module user_func_sel #(
  parameter int            FW       = 8,
  parameter int            NFUNC    = 32,
  parameter logic [FW-1:0] DSY_CODE = 8'h3F,
  parameter logic [FW-1:0] CMD_BASE = 8'h40,
  parameter int            NCMD     = 16,
  parameter int            STB_LEN  = 4
) (
  input  logic             TCK,
  input  logic             RST,
  input  logic             SEL1,
  input  logic             CAPTURE,
  input  logic             SHIFT,
  input  logic             UPDATE,
  input  logic             TDI,
  output logic             TDO,
  output logic [FW-1:0]    FUNC,
  output logic [NFUNC-1:0] FSEL,
  output logic             DSY_CHAIN,
  output logic [NCMD-1:0]  CMD_STB,
  output logic             BUSY,
  output logic             ILLEGAL
);

  localparam int          CW      = (STB_LEN > 1) ? $clog2(STB_LEN) : 1;
  localparam logic [FW:0] NFUNC_W = (FW+1)'(NFUNC);
  localparam logic [FW:0] NCMD_W  = (FW+1)'(NCMD);

  logic [FW-1:0]    r_ir_sr;
  logic [FW-1:0]    r_func;
  logic [NFUNC-1:0] r_fsel;
  logic             r_dsy;
  logic             r_illegal;
  logic [NCMD-1:0]  r_cmd_stb;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;

  logic             w_upd;
  logic [FW:0]      w_cmd_off;
  logic [NCMD-1:0]  w_cmd_onehot;
  logic [NFUNC-1:0] w_fsel_nx;
  logic             w_dsy_nx;
  logic             w_ill_nx;
  logic             w_is_cmd;

  assign w_upd        = SEL1 & UPDATE;
  // Codes below CMD_BASE wrap to a large offset and fall outside the command range.
  assign w_cmd_off    = {1'b0, r_ir_sr} - {1'b0, CMD_BASE};
  assign w_cmd_onehot = NCMD'(1) << w_cmd_off[FW-1:0];

  always_comb begin
    w_fsel_nx = '0;
    w_dsy_nx  = 1'b0;
    w_ill_nx  = 1'b0;
    w_is_cmd  = 1'b0;
    if (r_ir_sr != '0) begin
      if ({1'b0, r_ir_sr} < NFUNC_W)
        w_fsel_nx = NFUNC'(1) << r_ir_sr;
      else if (r_ir_sr == DSY_CODE)
        w_dsy_nx = 1'b1;
      else if (w_cmd_off < NCMD_W)
        w_is_cmd = 1'b1;
      else
        w_ill_nx = 1'b1;
    end
  end

  always_ff @(posedge TCK or posedge RST) begin
    if (RST) begin
      r_ir_sr   <= '0;
      r_func    <= '0;
      r_fsel    <= '0;
      r_dsy     <= 1'b0;
      r_illegal <= 1'b0;
      r_cmd_stb <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
    end else begin
      if (w_upd) begin
        r_func    <= r_ir_sr;
        r_fsel    <= w_fsel_nx;
        r_dsy     <= w_dsy_nx;
        r_illegal <= w_ill_nx;
      end else if (SEL1 && CAPTURE) begin
        r_ir_sr <= r_func;
      end else if (SEL1 && SHIFT) begin
        r_ir_sr <= {TDI, r_ir_sr[FW-1:1]};
      end

      // A new command restarts the strobe; any other update lets it run out.
      if (w_upd && w_is_cmd) begin
        r_cmd_stb <= w_cmd_onehot;
        r_cnt     <= CW'(STB_LEN - 1);
        r_busy    <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == '0) begin
          r_cmd_stb <= '0;
          r_busy    <= 1'b0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign TDO       = SEL1 & r_ir_sr[0];
  assign FUNC      = r_func;
  assign FSEL      = r_fsel;
  assign DSY_CHAIN = r_dsy;
  assign CMD_STB   = r_cmd_stb;
  assign BUSY      = r_busy;
  assign ILLEGAL   = r_illegal;

endmodule

// File: tb/tb_user_func_sel.sv
// Directed bench for user_func_sel: shift/update/capture paths, decode classes,
// command strobe length, restart/continuation while busy, and async reset.
module tb_user_func_sel;

  logic        TCK = 1'b0;
  logic        RST = 1'b1;
  logic        SEL1 = 1'b0, CAPTURE = 1'b0, SHIFT = 1'b0, UPDATE = 1'b0, TDI = 1'b0;
  logic        TDO;
  logic [7:0]  FUNC;
  logic [31:0] FSEL;
  logic        DSY_CHAIN;
  logic [15:0] CMD_STB;
  logic        BUSY;
  logic        ILLEGAL;

  int total = 0;
  int bad   = 0;

  user_func_sel dut (
    .TCK(TCK), .RST(RST), .SEL1(SEL1), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
    .UPDATE(UPDATE), .TDI(TDI), .TDO(TDO), .FUNC(FUNC), .FSEL(FSEL),
    .DSY_CHAIN(DSY_CHAIN), .CMD_STB(CMD_STB), .BUSY(BUSY), .ILLEGAL(ILLEGAL)
  );

  always #5 TCK = ~TCK;

  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_code(input logic [7:0] code);
    SEL1  = 1'b1;
    SHIFT = 1'b1;
    for (int i = 0; i < 8; i++) begin
      TDI = code[i];
      tick();
    end
    SHIFT = 1'b0;
    TDI   = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    SEL1 = 1'b1; SHIFT = 1'b1; TDI = b;
    tick();
    SHIFT = 1'b0; TDI = 1'b0;
  endtask

  task automatic do_update();
    SEL1 = 1'b1; UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
  endtask

  task automatic chk_strobe(input string tag, input logic [15:0] stb, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_stb"}, {16'h0, CMD_STB}, {16'h0, stb});
      chk({tag, "_busy"}, {31'h0, BUSY}, 32'h1);
      tick();
    end
    chk({tag, "_stb_end"}, {16'h0, CMD_STB}, 32'h0);
    chk({tag, "_busy_end"}, {31'h0, BUSY}, 32'h0);
  endtask

  initial begin
    logic [7:0] rb;

    // reset
    tick(); tick();
    RST = 1'b0;
    tick();
    chk("rst_func", {24'h0, FUNC}, 32'h0);
    chk("rst_fsel", FSEL, 32'h0);
    chk("rst_stb", {16'h0, CMD_STB}, 32'h0);
    chk("rst_tdo", {31'h0, TDO}, 32'h0);
    chk("rst_ill", {31'h0, ILLEGAL}, 32'h0);

    // register select
    shift_code(8'h05);
    do_update();
    chk("sel_func", {24'h0, FUNC}, 32'h05);
    chk("sel_fsel", FSEL, 32'h0000_0020);
    chk("sel_dsy", {31'h0, DSY_CHAIN}, 32'h0);

    // capture and readback
    SEL1 = 1'b1; CAPTURE = 1'b1;
    tick();
    CAPTURE = 1'b0;
    rb = 8'h05;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rb_tdo%0d", i), {31'h0, TDO}, {31'h0, rb[i]});
      shift_bit(1'b0);
    end
    chk("rb_fsel_hold", FSEL, 32'h0000_0020);
    chk("rb_func_hold", {24'h0, FUNC}, 32'h05);

    // single command strobe
    shift_code(8'h42);
    do_update();
    chk("cmd_fsel", FSEL, 32'h0);
    chk("cmd_func", {24'h0, FUNC}, 32'h42);
    chk_strobe("cmd42", 16'h0004, 4);

    // same command re-issued two cycles in: counter restarts
    do_update();
    chk("rst2_e0", {16'h0, CMD_STB}, 32'h0004);
    tick();
    chk("rst2_e1", {16'h0, CMD_STB}, 32'h0004);
    do_update();
    chk_strobe("restart", 16'h0004, 4);

    // switch to another command mid-stream: 0x42 >> 3 with TDI 0,1,0 gives 0x48
    do_update();
    shift_bit(1'b0);
    shift_bit(1'b1);
    shift_bit(1'b0);
    chk("sw_old", {16'h0, CMD_STB}, 32'h0004);
    do_update();
    chk("sw_func", {24'h0, FUNC}, 32'h48);
    chk_strobe("sw48", 16'h0100, 4);

    // undefined code while busy: strobe runs to completion
    do_update();
    shift_bit(1'b0);
    do_update();
    chk("nc_func", {24'h0, FUNC}, 32'h24);
    chk("nc_ill", {31'h0, ILLEGAL}, 32'h1);
    chk_strobe("nc_cont", 16'h0100, 2);

    // daisy chain
    shift_code(8'h3F);
    do_update();
    chk("dsy_chain", {31'h0, DSY_CHAIN}, 32'h1);
    chk("dsy_fsel", FSEL, 32'h0);
    chk("dsy_ill", {31'h0, ILLEGAL}, 32'h0);

    // illegal code, then update without SEL1 is ignored
    shift_code(8'h30);
    do_update();
    chk("ill_flag", {31'h0, ILLEGAL}, 32'h1);
    chk("ill_fsel", FSEL, 32'h0);
    chk("ill_dsy", {31'h0, DSY_CHAIN}, 32'h0);
    SEL1 = 1'b0; UPDATE = 1'b1;
    tick();
    UPDATE = 1'b0;
    chk("nosel_func", {24'h0, FUNC}, 32'h30);
    chk("nosel_ill", {31'h0, ILLEGAL}, 32'h1);

    // reset mid-strobe
    shift_code(8'h42);
    do_update();
    chk("pre_rst_ill", {31'h0, ILLEGAL}, 32'h0);
    tick();
    chk("pre_rst_stb", {16'h0, CMD_STB}, 32'h0004);
    RST = 1'b1;
    #1;
    chk("arst_stb", {16'h0, CMD_STB}, 32'h0);
    chk("arst_busy", {31'h0, BUSY}, 32'h0);
    chk("arst_func", {24'h0, FUNC}, 32'h0);
    tick();
    RST = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_stb", {16'h0, CMD_STB}, 32'h0);
    chk("post_rst_tdo", {31'h0, TDO}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
